// File: rtl/eth_tx_fcs_sequencer.sv
// Ethernet TX frame sequencer: forwards frame content, appends the CRC-32 FCS and
// enforces an inter-frame gap. Optional zero padding to MIN_FRAME via `define ETH_TX_PAD_EN.
module eth_tx_fcs_sequencer #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PAD, ST_FCS, ST_IFG} state_e;

  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam int unsigned IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int unsigned IFG_LAST_I = (IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_LAST_I[IFG_W-1:0];

  if (MIN_FRAME > 32'd65535) begin : g_bad_min_frame
    $error("MIN_FRAME exceeds the 16-bit byte counter range");
  end

  // One byte through the MSB-first CRC register, data bits taken LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = ~crc[31-i];
    end
    return r[{k, 3'b000} +: 8];
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d;
  logic [1:0]       fcs_idx_q, fcs_idx_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             frame_done_q, frame_done_d;

  logic        out_free;
  logic        s_fire;
  logic        m_fire;
  logic [15:0] cnt_inc;

  assign out_free = !m_valid_q || m_ready;
  assign s_ready  = rstn && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_free;
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid_q && m_ready;
  assign cnt_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

`ifdef ETH_TX_PAD_EN
  localparam logic [15:0] MIN_CNT = MIN_FRAME[15:0];
`endif

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    fcs_idx_d    = fcs_idx_q;
    ifg_cnt_d    = ifg_cnt_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q && !m_ready;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      // crc_q is already CRC_INIT and byte_cnt_q zero whenever the FSM sits in IDLE.
      ST_IDLE, ST_DATA: begin
        if (s_fire) begin
          m_data_d   = s_data;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b0;
          crc_d      = crc_step(crc_q, s_data);
          byte_cnt_d = cnt_inc;
          if (s_last) begin
`ifdef ETH_TX_PAD_EN
            state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
`else
            state_d = ST_FCS;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        if (out_free) begin
          m_data_d   = 8'h00;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b0;
          crc_d      = crc_step(crc_q, 8'h00);
          byte_cnt_d = cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            state_d = ST_FCS;
          end
        end
      end
`endif
      ST_FCS: begin
        if (m_fire && m_last_q) begin
          m_last_d     = 1'b0;
          frame_done_d = 1'b1;
          crc_d        = CRC_INIT;
          byte_cnt_d   = 16'd0;
          ifg_cnt_d    = '0;
          state_d      = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
        end else if (out_free && !m_last_q) begin
          // fcs_idx wraps back to 0 after byte 3, ready for the next frame.
          m_data_d  = fcs_byte(crc_q, fcs_idx_q);
          m_valid_d = 1'b1;
          m_last_d  = (fcs_idx_q == 2'd3);
          fcs_idx_d = fcs_idx_q + 2'd1;
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      byte_cnt_q   <= 16'd0;
      fcs_idx_q    <= 2'd0;
      ifg_cnt_q    <= '0;
      m_data_q     <= 8'h00;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      fcs_idx_q    <= fcs_idx_d;
      ifg_cnt_q    <= ifg_cnt_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_eth_tx_fcs_sequencer.sv
// Self-checking bench for eth_tx_fcs_sequencer: a frame-level model predicts every
// output byte, m_last and frame_done; directed tests pin known CRC-32 values.
module tb_eth_tx_fcs_sequencer;

  localparam int IFG  = 12;
  localparam int MINF = 60;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } out_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  eth_tx_fcs_sequencer #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
    .clk(clk), .rstn(rstn),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC-32 in the usual reflected software form.
  function automatic logic [31:0] crc32_sw(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // ---------------- model + compare process ----------------
  out_t    exp_q[$];
  byte_q_t cur_frame;
  byte_q_t cap_cur;
  byte_q_t cap_last;
  int      done_seen = 0;
  logic    done_exp = 1'b0;
  logic    stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic    prev_last = 1'b0;
  logic    measuring = 1'b0;
  int      ifg_run = 0;
  int      ifg_lens[$];
  bit      pad_en;

  initial begin
`ifdef ETH_TX_PAD_EN
    pad_en = 1'b1;
`else
    pad_en = 1'b0;
`endif
  end

  always @(negedge clk) begin
    out_t       e;
    logic [31:0] c;
    if (!rstn) begin
      exp_q.delete();
      cur_frame.delete();
      cap_cur.delete();
      done_exp   = 1'b0;
      stall_prev = 1'b0;
      measuring  = 1'b0;
    end else begin
      check("frame_done", frame_done, done_exp);
      if (frame_done) begin
        done_seen++;
        measuring = 1'b1;
        ifg_run   = 0;
      end
      if (measuring) begin
        if (!s_ready) ifg_run++;
        else begin
          ifg_lens.push_back(ifg_run);
          measuring = 1'b0;
        end
      end
      if (stall_prev) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got byte 0x%0h, required no output", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
        end
        cap_cur.push_back(m_data);
        if (m_last) begin
          cap_last = cap_cur;
          cap_cur.delete();
        end
      end
      done_exp   = m_valid && m_ready && m_last;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (s_valid && s_ready) begin
        cur_frame.push_back(s_data);
        exp_q.push_back('{last: 1'b0, data: s_data});
        if (s_last) begin
          while (pad_en && cur_frame.size() < MINF) begin
            cur_frame.push_back(8'h00);
            exp_q.push_back('{last: 1'b0, data: 8'h00});
          end
          c = crc32_sw(cur_frame);
          for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{last: (k == 3), data: c[8*k +: 8]});
          end
          cur_frame.delete();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rdy_rand = 1'b0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input byte_q_t f, input bit with_last);
    int  n;
    bit  acc;
    foreach (f[i]) begin
      s_valid = 1'b1;
      s_data  = f[i];
      s_last  = with_last && (i == f.size() - 1);
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 5000) begin
          total++;
          bad++;
          $display("FAIL send_timeout: byte %0d not accepted, required acceptance within 5000 cycles", i);
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_count", done_seen, target);
    repeat (IFG + 3) @(posedge clk);
    #1;
  endtask

  byte_q_t s9, one_a, one_aa, f64, ref64;
  int      frames;
  int      exp_len;

  initial begin
    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
    one_a.push_back(8'h61);
    one_aa.push_back(8'hAA);
    for (int i = 0; i < 64; i++) f64.push_back(8'(i * 7 + 3));
    frames = 0;

    // Model pins against well-known CRC-32 values.
    check("model_crc_123456789", crc32_sw(s9), 32'hCBF4_3926);
    check("model_crc_a", crc32_sw(one_a), 32'hE8B7_BE43);

    // Reset state.
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Check value frame.
    send(s9, 1'b1);
    frames++;
    wait_done(frames);
    exp_len = pad_en ? MINF + 4 : 13;
    check("s9_len", cap_last.size(), exp_len);
`ifndef ETH_TX_PAD_EN
    if (cap_last.size() == 13)
      check("s9_fcs", {cap_last[12], cap_last[11], cap_last[10], cap_last[9]}, 32'hCBF4_3926);
`endif

    // Single-byte frame.
    send(one_a, 1'b1);
    frames++;
    wait_done(frames);
    exp_len = pad_en ? MINF + 4 : 5;
    check("one_len", cap_last.size(), exp_len);
`ifndef ETH_TX_PAD_EN
    if (cap_last.size() == 5)
      check("one_fcs", {cap_last[4], cap_last[3], cap_last[2], cap_last[1]}, 32'hE8B7_BE43);
`endif

    // Padding candidate (padded only when the feature is built in).
    send(one_aa, 1'b1);
    frames++;
    wait_done(frames);
    exp_len = pad_en ? 64 : 5;
    check("pad_len", cap_last.size(), exp_len);

    // Backpressure: same 64-byte frame with m_ready=1 then ~30% duty.
    send(f64, 1'b1);
    frames++;
    wait_done(frames);
    ref64 = cap_last;
    check("f64_len", ref64.size(), 68);
    rdy_rand = 1'b1;
    send(f64, 1'b1);
    frames++;
    wait_done(frames);
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    check("bp_len", cap_last.size(), ref64.size());
    if (cap_last.size() == ref64.size())
      foreach (ref64[i]) check("bp_byte", cap_last[i], ref64[i]);

    // Back-to-back frames with s_valid held high: gap length and CRC re-init.
    ifg_lens.delete();
    send(s9, 1'b1);
    send(s9, 1'b1);
    frames += 2;
    wait_done(frames);
    check("ifg_meas_count", ifg_lens.size(), 2);
    if (ifg_lens.size() >= 1) check("ifg_len_first", ifg_lens[0], IFG);
`ifndef ETH_TX_PAD_EN
    if (cap_last.size() == 13)
      check("b2b_second_fcs", {cap_last[12], cap_last[11], cap_last[10], cap_last[9]}, 32'hCBF4_3926);
`endif

    // Reset after 10 data bytes, then a clean frame.
    send(f64[0:9], 1'b0);
    check("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_s_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_m_valid", m_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_m_last", m_last, 1'b0);
    @(posedge clk);
    #1;
    send(s9, 1'b1);
    frames++;
    wait_done(frames);
`ifndef ETH_TX_PAD_EN
    if (cap_last.size() == 13)
      check("post_rst_fcs", {cap_last[12], cap_last[11], cap_last[10], cap_last[9]}, 32'hCBF4_3926);
`endif
    check("post_rst_len", cap_last.size(), pad_en ? MINF + 4 : 13);

    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_fcs_sequencer.md
# eth_tx_fcs_sequencer

Transmit-side frame sequencer for the Ethernet MAC path. It takes a byte stream of frame contents (destination address through payload), passes each byte through to the MAC transmit interface, and accumulates the CRC-32 frame check sequence. After the last byte it appends the four FCS bytes, then holds off the next frame for a programmable inter-frame gap. It sits between the TX buffer reader and the byte-wide MAC transmit serialiser, and it owns the CRC-32 update datapath.

## Interface
- IFG_CYCLES, default 12: idle cycles enforced after the last FCS byte is accepted.
- MIN_FRAME, default 60: minimum byte count before the FCS; only used when padding is compiled in.

Ports (clock and reset first):
- clk  in  1  single clock for all logic.
- rstn  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- s_data  in  8  frame byte from the TX buffer.
- s_valid  in  1  s_data is valid.
- s_last  in  1  this is the final content byte of the frame.
- s_ready  out  1  sequencer accepts s_data this cycle.
- m_data  out  8  byte to the MAC.
- m_valid  out  1  m_data is valid.
- m_last  out  1  final byte of the frame (the last FCS byte).
- m_ready  in  1  MAC accepts m_data this cycle.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last FCS byte is accepted.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on a clock edge. m_valid, m_data and m_last are registered and stay stable until accepted.
- s_ready = (state is IDLE or DATA) and (!m_valid or m_ready).
- CRC register: 32 bits, set to 0xFFFFFFFF in IDLE.
- CRC update per transmitted content byte or pad byte: for i = 0..7 (LSB first), feedback = crc[31] ^ byte[i]; crc = {crc[30:0],0} ^ (feedback ? 0x04C11DB7 : 0).
- FCS: r = bit-reverse(crc); FCS byte k (k = 0..3, sent in that order) = ~r[8k+7:8k].
- States:
  - IDLE: wait for s_valid. On the first accepted byte, go to DATA.
  - DATA: forward bytes and update the CRC. On acceptance of the s_last byte, go to PAD if padding is enabled and byte_cnt+1 < MIN_FRAME; otherwise go to FCS.
  - PAD: emit 0x00 bytes and update the CRC until byte_cnt reaches MIN_FRAME, then go to FCS.
  - FCS: emit FCS bytes 0..3 from the CRC frozen at entry. Byte 3 carries m_last. On its acceptance, pulse frame_done and go to IFG.
  - IFG: s_ready is low. Count IFG_CYCLES cycles, then go to IDLE. If IFG_CYCLES is 0, go straight to IDLE.
- byte_cnt: 16 bits, counts content and pad bytes, and saturates at 0xFFFF with no wrap. Its value does not affect the FCS.
- s_valid is ignored in PAD, FCS and IFG. The upstream block holds its byte until s_ready is high.
- s_last on the first byte gives a 1-byte frame (with padding disabled: 1 data byte + 4 FCS bytes).
- Reset mid-frame: all state is discarded on the next edge, with no partial FCS. The MAC detects the truncated frame from the loss of m_valid.

## Timing
- Reset values: m_valid=0, m_data=0x00, m_last=0, s_ready=0 during reset, busy=0, frame_done=0, CRC=0xFFFFFFFF, byte_cnt=0, state=IDLE.
- Latency: 1 cycle from input acceptance to m_valid/m_data.
- With m_ready held high: one byte per cycle, no bubble from DATA to PAD to FCS. The first FCS byte appears the cycle after the last data or pad byte.
- Backpressure: m_ready low stalls all progress. The CRC updates only on input acceptance (DATA) or pad-byte emission (PAD).
- The CRC is computed combinationally from the incoming byte within one cycle (8-step unrolled), then registered.

## Configuration
- ETH_TX_PAD_EN defined: frames shorter than MIN_FRAME content bytes are zero-padded in the PAD state, and the pad bytes are included in the CRC.
- ETH_TX_PAD_EN undefined: the PAD state and the MIN_FRAME comparison are absent. FCS always follows the s_last byte directly, and MIN_FRAME is unused.

## Test plan
- Check value: ASCII "123456789" (0x31..0x39) with padding disabled and m_ready=1 -> 13 output bytes, with FCS 0x26,0x39,0xF4,0xCB; m_last only on 0xCB; one frame_done pulse.
- Padding: one byte 0xAA with ETH_TX_PAD_EN and MIN_FRAME=60 -> 0xAA, then 59×0x00, then the FCS of those 60 bytes (matches a software CRC-32); 64 output bytes total.
- Backpressure: a random m_ready duty of about 30% on a 64-byte frame -> output byte sequence identical to the m_ready=1 run; m_data stable while m_valid && !m_ready.
- IFG: two back-to-back frames with s_valid always high and IFG_CYCLES=12 -> s_ready low for exactly 12 cycles after the first frame_done; the second FCS is correct (CRC re-initialised).
- Reset mid-frame: rstn low for 1 cycle after 10 data bytes -> the next cycle shows m_valid=0, busy=0, state IDLE; the following frame "123456789" still yields 0xCBF43926.
- Single-byte frame (s_last on the first byte, no padding) -> 5 output bytes with FCS equal to the software CRC-32 of that byte.
